// File: rtl/msfsm_mealy_node_param.sv
// msfsm_mealy_node_param: one-hot Mealy FSM node; in t_req/tb_in, out t_ack (comb), state_out/fire/fire_count/illegal (registered)
module msfsm_mealy_node_param #(
  parameter int N_STATES = 3,
  parameter int N_TRANS = 4,
  parameter int N_PEERS = 3,
  parameter int CNT_W = 8,
  parameter logic [N_STATES-1:0] RESET_STATE = 3'b100,
  parameter logic [N_TRANS*N_STATES-1:0] TR_SRC = 12'b010_100_100_001,
  parameter logic [N_TRANS*N_STATES-1:0] TR_DST = 12'b001_001_010_100,
  parameter logic [N_TRANS*N_PEERS-1:0] TB_MASK = 12'b000_000_000_111
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_TRANS-1:0]         t_req,
  input  logic [N_TRANS*N_PEERS-1:0] tb_in,
  output logic [N_TRANS-1:0]         t_ack,
  output logic [N_STATES-1:0]        state_out,
  output logic [N_TRANS-1:0]         fire,
  output logic [CNT_W-1:0]           fire_count,
  output logic                       illegal
);
  logic [N_STATES-1:0] state, dst;
  logic [N_TRANS-1:0] en;
  logic legal;
  function automatic logic onehot(input logic [N_STATES-1:0] v);
    return v != '0 && (v & (v - N_STATES'(1))) == '0;
  endfunction
  assign legal = onehot(state);
  assign state_out = state;
  for (genvar t = 0; t < N_TRANS; t++) begin : g_tr
    assign en[t] = |(state & TR_SRC[t*N_STATES +: N_STATES]) & t_req[t]
                   & (&(tb_in[t*N_PEERS +: N_PEERS] | ~TB_MASK[t*N_PEERS +: N_PEERS]));
    if (!onehot(TR_SRC[t*N_STATES +: N_STATES]) || !onehot(TR_DST[t*N_STATES +: N_STATES]))
      $error("transition %0d: SRC/DST not one-hot", t);
  end
  if (!onehot(RESET_STATE)) $error("RESET_STATE not one-hot");
  always_comb begin
    t_ack = (reset || !legal) ? '0 : en & (~en + N_TRANS'(1));
    dst = '0;
    for (int k = 0; k < N_TRANS; k++) dst |= t_ack[k] ? TR_DST[k*N_STATES +: N_STATES] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      fire <= '0;
      fire_count <= '0;
      illegal <= 1'b0;
    end else begin
      state <= !legal ? RESET_STATE : (|t_ack ? dst : state);
      fire <= t_ack;
      fire_count <= fire_count + CNT_W'(|t_ack);
      illegal <= illegal | !legal;
    end
  end
endmodule

// File: tb/tb_msfsm_mealy_node_param.sv
// tb_msfsm_mealy_node_param: directed scoreboard bench for msfsm_mealy_node_param
module tb_msfsm_mealy_node_param;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] t_req;
  logic [11:0] tb_in;
  logic [3:0] t_ack;
  logic [2:0] state_out;
  logic [3:0] fire;
  logic [7:0] fire_count;
  logic illegal;
  typedef struct {
    logic [3:0] f;
    logic [2:0] s;
    logic [7:0] c;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int errors = 0;
  logic [7:0] mcnt = '0;
  always #5 clk = ~clk;
  msfsm_mealy_node_param dut (
    .clk(clk), .reset(reset), .t_req(t_req), .tb_in(tb_in), .t_ack(t_ack),
    .state_out(state_out), .fire(fire), .fire_count(fire_count), .illegal(illegal)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (fire !== 4'b0) begin
      if (q.size() == 0) check("unexpected_fire", 32'(fire), 32'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("fire", 32'(fire), 32'(e.f));
        check("fire_state", 32'(state_out), 32'(e.s));
        check("fire_count", 32'(fire_count), 32'(e.c));
      end
    end
  end
  task automatic step(input logic [3:0] rq, input logic [11:0] tb, input logic [3:0] ack,
                      input logic [2:0] nst, input string nm);
    @(negedge clk);
    t_req = rq;
    tb_in = tb;
    #1;
    check({nm, "_ack"}, 32'(t_ack), 32'(ack));
    if (ack != 4'b0) begin
      mcnt = mcnt + 8'd1;
      q.push_back('{f: ack, s: nst, c: mcnt});
    end
    @(posedge clk);
    #1;
    if (ack == 4'b0) begin
      check({nm, "_hold_state"}, 32'(state_out), 32'(nst));
      check({nm, "_hold_fire"}, 32'(fire), 32'h0);
    end
  endtask
  task automatic do_reset(input logic [3:0] rq, input string nm);
    @(negedge clk);
    reset = 1'b1;
    t_req = rq;
    tb_in = 12'hfff;
    #1;
    check({nm, "_ack"}, 32'(t_ack), 32'h0);
    @(posedge clk);
    #1;
    check({nm, "_state"}, 32'(state_out), 32'h4);
    check({nm, "_fire"}, 32'(fire), 32'h0);
    check({nm, "_count"}, 32'(fire_count), 32'h0);
    check({nm, "_illegal"}, 32'(illegal), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    t_req = 4'b0;
    mcnt = '0;
  endtask
  initial begin
    reset = 1'b1;
    t_req = 4'($urandom);
    tb_in = 12'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_state", 32'(state_out), 32'h4);
      check("rst_fire", 32'(fire), 32'h0);
      check("rst_count", 32'(fire_count), 32'h0);
      check("rst_illegal", 32'(illegal), 32'h0);
      @(negedge clk);
      t_req = 4'($urandom);
      tb_in = 12'($urandom);
      #1;
      check("rst_ack", 32'(t_ack), 32'h0);
    end
    reset = 1'b0;
    t_req = 4'b0;
    tb_in = 12'h0;
    step(4'b0110, 12'h000, 4'b0010, 3'b010, "choice_t1");
    step(4'b1000, 12'h000, 4'b1000, 3'b001, "t3");
    step(4'b0001, 12'h007, 4'b0001, 3'b100, "t0");
    step(4'b0100, 12'h000, 4'b0100, 3'b001, "choice_t2");
    for (int i = 0; i < 3; i++) step(4'b0001, 12'hffb, 4'b0000, 3'b001, "barrier_wait");
    step(4'b0001, 12'hfff, 4'b0001, 3'b100, "barrier_met");
    do_reset(4'b0000, "rst_pre_wrap");
    for (int i = 0; i < 86; i++) begin
      step(4'b0010, 12'h007, 4'b0010, 3'b010, "wrap_t1");
      step(4'b1000, 12'h007, 4'b1000, 3'b001, "wrap_t3");
      step(4'b0001, 12'h007, 4'b0001, 3'b100, "wrap_t0");
    end
    check("wrap_count", 32'(fire_count), 32'h2);
    check("wrap_state", 32'(state_out), 32'h4);
    @(negedge clk);
    t_req = 4'b1111;
    tb_in = 12'hfff;
    force dut.state = 3'b011;
    #1;
    check("illegal_ack", 32'(t_ack), 32'h0);
    check("illegal_seen", 32'(state_out), 32'h3);
    @(posedge clk);
    #1;
    release dut.state;
    t_req = 4'b0;
    check("illegal_flag", 32'(illegal), 32'h1);
    check("illegal_fire", 32'(fire), 32'h0);
    @(posedge clk);
    #1;
    check("illegal_recover_state", 32'(state_out), 32'h4);
    check("illegal_count_hold", 32'(fire_count), 32'h2);
    step(4'b0010, 12'h000, 4'b0010, 3'b010, "post_illegal_t1");
    step(4'b1000, 12'h000, 4'b1000, 3'b001, "post_illegal_t3");
    check("illegal_sticky", 32'(illegal), 32'h1);
    do_reset(4'b0000, "rst_clear_illegal");
    step(4'b0010, 12'h000, 4'b0010, 3'b010, "pre_mid_t1");
    step(4'b1000, 12'h000, 4'b1000, 3'b001, "pre_mid_t3");
    step(4'b0001, 12'h007, 4'b0001, 3'b100, "pre_mid_t0");
    do_reset(4'b0010, "rst_mid_op");
    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
